// File: rtl/mips_data_mem.sv
// Data memory for the MIPS core: byte/half/word stores with lane enables,
// sign/zero-extended sub-word loads, valid/ready handshake and access error flagging.
module mips_data_mem #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_hold;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_accept = req_valid && w_ready && !rst;
  assign w_idx    = req_addr[ADDR_WIDTH+1:2];

  // Illegal size, misalignment, or any address bit above the storage range.
  always_comb begin
    w_err = 1'b0;
    if (req_size == 2'b11)                              w_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])               w_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)    w_err = 1'b1;
    if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0)        w_err = 1'b1;
  end

  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{req_addr[1:0], 3'b000} +: 8];
    w_half = w_word[{req_addr[1], 4'b0000} +: 16];
    case (req_size)
      2'b00:   w_load = {{24{req_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{req_signed & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_be       = 4'b1111;
    w_wdata_sh = req_wdata;
    case (req_size)
      2'b00: begin
        w_be       = 4'b0001 << req_addr[1:0];
        w_wdata_sh = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_sh = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_hold      <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_hold;
            r_rsp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          if (w_accept && (w_err || req_we || READ_LATENCY == 1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (w_err || req_we) ? 32'd0 : w_load;
            r_rsp_err   <= w_err;
          end else if (w_accept) begin
            // Load data is captured at accept and held until the response cycle.
            r_state     <= ST_WAIT;
            r_cnt       <= CNT_INIT;
            r_hold      <= w_load;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
          end else begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem: directed vector table, handshake corner
// sequences and randomized traffic against a byte-array reference model.
module tb_mips_data_mem;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  mips_data_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] ref_mem [0:(4 << AW) - 1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.sz = sz; v.sg = sg; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One complete transaction; lat = cycles from accept edge to rsp_valid, -1 on timeout.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int guard;
    rd = 32'd0; er = 1'b0; lat = -1;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  // Reference model: memory as a flat byte array, results built with plain arithmetic.
  task automatic model_op(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] exp_rd, output logic exp_er);
    int unsigned nbytes;
    logic [31:0] val;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_er = (sz == 2'd3) || (a % nbytes != 0) || (a >= (32'd4 << AW));
    exp_rd = 32'd0;
    if (exp_er) return;
    if (we) begin
      for (int unsigned k = 0; k < nbytes; k++) ref_mem[a + k] = 8'((wd >> (8 * k)) % 256);
    end else begin
      val = 32'd0;
      for (int unsigned k = 0; k < nbytes; k++) val = val + ({24'd0, ref_mem[a + k]} << (8 * k));
      if (sg && nbytes == 1 && val >= 128)   val = val - 256;
      if (sg && nbytes == 2 && val >= 32768) val = val - 65536;
      exp_rd = val;
    end
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat, cnt;
    logic        we, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    add("st w 0x10",        1, 2'd2, 0, 32'h10,       32'h11223344, 32'h0,        0);
    add("ld w 0x10",        0, 2'd2, 0, 32'h10,       32'h0,        32'h11223344, 0);
    add("st b 0x11",        1, 2'd0, 0, 32'h11,       32'h123456AB, 32'h0,        0);
    add("ld bu 0x11",       0, 2'd0, 0, 32'h11,       32'h0,        32'h000000AB, 0);
    add("ld bs 0x11",       0, 2'd0, 1, 32'h11,       32'h0,        32'hFFFFFFAB, 0);
    add("ld w after b",     0, 2'd2, 0, 32'h10,       32'h0,        32'h1122AB44, 0);
    add("st h 0x12",        1, 2'd1, 0, 32'h12,       32'hDEAD8001, 32'h0,        0);
    add("ld hs 0x12",       0, 2'd1, 1, 32'h12,       32'h0,        32'hFFFF8001, 0);
    add("st h 0x13 misal",  1, 2'd1, 0, 32'h13,       32'h00005555, 32'h0,        1);
    add("ld w unchanged",   0, 2'd2, 0, 32'h10,       32'h0,        32'h8001AB44, 0);
    add("st w oor",         1, 2'd2, 0, 32'h1000,     32'hFFFFFFFF, 32'h0,        1);
    add("st w alias",       1, 2'd2, 0, 32'h1010,     32'hFFFFFFFF, 32'h0,        1);
    add("ld size11",        0, 2'd3, 0, 32'h10,       32'h0,        32'h0,        1);
    add("st size11",        1, 2'd3, 0, 32'h10,       32'hFFFFFFFF, 32'h0,        1);
    add("ld w no alias",    0, 2'd2, 1, 32'h10,       32'h0,        32'h8001AB44, 0);
    add("ld hu 0x10",       0, 2'd1, 0, 32'h10,       32'h0,        32'h0000AB44, 0);
    add("ld hs 0x10",       0, 2'd1, 1, 32'h10,       32'h0,        32'hFFFFAB44, 0);
    add("ld bs 0x10",       0, 2'd0, 1, 32'h10,       32'h0,        32'h00000044, 0);
    add("ld bu 0x13",       0, 2'd0, 0, 32'h13,       32'h0,        32'h00000080, 0);
    add("ld bs 0x13",       0, 2'd0, 1, 32'h13,       32'h0,        32'hFFFFFF80, 0);
    add("ld w misal",       0, 2'd2, 0, 32'h12,       32'h0,        32'h0,        1);
    add("ld w bit31",       0, 2'd2, 0, 32'h80000010, 32'h0,        32'h0,        1);

    foreach (vecs[i]) begin
      do_op(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, " err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      check({vecs[i].name, " latency"}, lat,
            (!vecs[i].we && !vecs[i].exp_err) ? LAT : 1);
    end

    // Multi-cycle load with req_valid held; a store is accepted in the RESP cycle.
    @(negedge clk);
    req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h10; req_valid = 1;
    @(negedge clk);
    check("wait1 ready", {31'd0, req_ready}, 32'd0);
    check("wait1 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("wait1 rdata", rsp_rdata, 32'd0);
    req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("wait2 ready", {31'd0, req_ready}, 32'd0);
    check("wait2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("resp rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp rdata", rsp_rdata, 32'h8001AB44);
    check("resp ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("chained st rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("chained st rdata", rsp_rdata, 32'd0);
    check("chained st err", {31'd0, rsp_err}, 32'd0);
    req_valid = 0;
    @(negedge clk);
    check("after resp idle", {31'd0, rsp_valid}, 32'd0);
    do_op(0, 2'd2, 0, 32'h20, 0, rd, er, lat);
    check("ld chained st", rd, 32'hCAFEF00D);

    // Back-to-back stores: one accepted every cycle.
    @(negedge clk);
    req_we = 1; req_size = 2'd2; req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h40 + 4 * i; req_wdata = 32'hA5000000 + i;
      check("b2b ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      check("b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      do_op(0, 2'd2, 0, 32'h40 + 4 * i, 0, rd, er, lat);
      check("b2b readback", rd, 32'hA5000000 + i);
    end

    // Reset during WAIT drops the response; RAM contents survive.
    @(negedge clk);
    req_we = 0; req_size = 2'd2; req_addr = 32'h44; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("pre-rst in wait", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("dropped rsp count", cnt, 32'd0);
    check("ready after rst", {31'd0, req_ready}, 32'd1);
    do_op(0, 2'd2, 0, 32'h44, 0, rd, er, lat);
    check("data survives rst", rd, 32'hA5000001);

    // Random traffic against the reference model over an initialized region.
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      model_op(1, 2'd2, 0, 4 * i, wd, exp_rd, exp_er);
      do_op(1, 2'd2, 0, 4 * i, wd, rd, er, lat);
    end
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) a = a + (32'd1 << $urandom_range(AW + 2, 31));
      model_op(we, sz, sg, a, wd, exp_rd, exp_er);
      do_op(we, sz, sg, a, wd, rd, er, lat);
      check("rand rdata", rd, exp_rd);
      check("rand err", {31'd0, er}, {31'd0, exp_er});
      check("rand latency", lat, (!we && !exp_er) ? LAT : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
